// File: rtl/vga_tile_render.sv
// vga_tile_render: tile-based background renderer with hardware scrolling.
// A pixel strobe from the timing generator enters a free-running 4-stage
// pipeline: tile-map lookup, tile-pixel lookup, colour output. Both RAMs
// have one clock of read latency. Syncs travel alongside the pixel so
// they leave aligned with the colour they belong to.
module vga_tile_render #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixel_en,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        display_in,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  output logic [12:0] tmap_addr,
  input  logic [7:0]  tmap_data,
  output logic [13:0] tpix_addr,
  input  logic [11:0] tpix_data,
  input  logic [9:0]  scroll_x,
  input  logic [9:0]  scroll_y,
  input  logic        scroll_wr,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        h_sync_out,
  output logic        v_sync_out,
  output logic        frame_start
);

  localparam logic [9:0]  H_MAX = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  V_MAX = 10'(V_ACTIVE - 1);
  localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM = 11'(V_ACTIVE);
  localparam logic [12:0] TILES_PER_ROW = 13'd80;

  // Sideband that rides with each pixel through the pipeline.
  typedef struct packed {
    logic disp;
    logic hs;
    logic vs;
    logic fs;
  } side_t;

  localparam side_t SIDE_IDLE = '{disp: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};

  // Clamp a scroll request to the last valid coordinate.
  function automatic logic [9:0] clamp_scroll(input logic [9:0] v, input logic [9:0] max_v);
    if (v > max_v) begin
      return max_v;
    end else begin
      return v;
    end
  endfunction

  // Add the scroll offset and wrap once around the active area.
  function automatic logic [9:0] wrap_coord(input logic [9:0] p, input logic [9:0] s,
                                            input logic [10:0] lim);
    logic [10:0] sum;
    sum = {1'b0, p} + {1'b0, s};
    if (sum >= lim) begin
      sum = sum - lim;
    end else begin
      sum = sum;
    end
    return sum[9:0];
  endfunction

  // Linear tile index: 80 tiles of 8x8 pixels per row.
  function automatic logic [12:0] tile_index(input logic [9:0] ex, input logic [9:0] ey);
    return (13'(ey[9:3]) * TILES_PER_ROW) + 13'(ex[9:3]);
  endfunction

  // Scroll registers
  logic [9:0] shadow_sx_q, shadow_sx_d, shadow_sy_q, shadow_sy_d;
  logic [9:0] active_sx_q, active_sx_d, active_sy_q, active_sy_d;

  // Stage 0 combinational signals
  logic       origin_s;
  logic [9:0] use_sx_s, use_sy_s, ex_s, ey_s;

  // Stage 1 (after E0)
  logic        v1_q, v1_d;
  logic [2:0]  fx1_q, fx1_d, fy1_q, fy1_d;
  side_t       side1_q, side1_d;
  logic [12:0] tmap_addr_q, tmap_addr_d;

  // Stage 2 (after E1)
  logic        v2_q, v2_d;
  logic [2:0]  fx2_q, fx2_d, fy2_q, fy2_d;
  side_t       side2_q, side2_d;

  // Stage 3 (after E2)
  logic        v3_q, v3_d;
  side_t       side3_q, side3_d;
  logic [13:0] tpix_addr_q, tpix_addr_d;

  // Stage 4 (after E3)
  logic        v4_q, v4_d;
  side_t       side4_q, side4_d;

  // Output registers (after E4)
  logic [11:0] rgb_q, rgb_d;
  logic        hso_q, hso_d, vso_q, vso_d, fs_q, fs_d;

  // Detect the frame-origin pixel and pick the scroll it must use; the
  // origin pixel already sees the freshly promoted shadow values.
  always_comb begin
    origin_s = pixel_en & (pixel_x == 10'd0) & (pixel_y == 10'd0);
    if (origin_s) begin
      use_sx_s = shadow_sx_q;
      use_sy_s = shadow_sy_q;
    end else begin
      use_sx_s = active_sx_q;
      use_sy_s = active_sy_q;
    end
    ex_s = wrap_coord(pixel_x, use_sx_s, H_LIM);
    ey_s = wrap_coord(pixel_y, use_sy_s, V_LIM);
  end

  // Shadow captures writes; active takes the old shadow at frame origin.
  always_comb begin
    shadow_sx_d = shadow_sx_q;
    shadow_sy_d = shadow_sy_q;
    active_sx_d = active_sx_q;
    active_sy_d = active_sy_q;
    if (scroll_wr) begin
      shadow_sx_d = clamp_scroll(scroll_x, H_MAX);
      shadow_sy_d = clamp_scroll(scroll_y, V_MAX);
    end else begin
      shadow_sx_d = shadow_sx_q;
      shadow_sy_d = shadow_sy_q;
    end
    if (origin_s) begin
      active_sx_d = shadow_sx_q;
      active_sy_d = shadow_sy_q;
    end else begin
      active_sx_d = active_sx_q;
      active_sy_d = active_sy_q;
    end
  end

  // Stage 1: sample the timing inputs and form the tile-map address.
  always_comb begin
    v1_d        = pixel_en;
    fx1_d       = fx1_q;
    fy1_d       = fy1_q;
    side1_d     = side1_q;
    tmap_addr_d = tmap_addr_q;
    if (pixel_en) begin
      fx1_d       = ex_s[2:0];
      fy1_d       = ey_s[2:0];
      side1_d     = '{disp: display_in, hs: h_sync_in, vs: v_sync_in, fs: origin_s};
      tmap_addr_d = tile_index(ex_s, ey_s);
    end else begin
      fx1_d       = fx1_q;
      fy1_d       = fy1_q;
      side1_d     = side1_q;
      tmap_addr_d = tmap_addr_q;
    end
  end

  // Stages 2-4: advance every clock; tile-pixel address formed in stage 3.
  always_comb begin
    v2_d        = v1_q;
    fx2_d       = fx1_q;
    fy2_d       = fy1_q;
    side2_d     = side1_q;
    v3_d        = v2_q;
    side3_d     = side2_q;
    tpix_addr_d = tpix_addr_q;
    v4_d        = v3_q;
    side4_d     = side3_q;
    if (v2_q) begin
      tpix_addr_d = {tmap_data, fy2_q, fx2_q};
    end else begin
      tpix_addr_d = tpix_addr_q;
    end
  end

  // Output stage: update only for a valid pixel, otherwise hold; the
  // frame-start flag is a single-clock pulse.
  always_comb begin
    rgb_d = rgb_q;
    hso_d = hso_q;
    vso_d = vso_q;
    fs_d  = 1'b0;
    if (v4_q) begin
      if (side4_q.disp) begin
        rgb_d = tpix_data;
      end else begin
        rgb_d = 12'h000;
      end
      hso_d = side4_q.hs;
      vso_d = side4_q.vs;
      fs_d  = side4_q.fs;
    end else begin
      rgb_d = rgb_q;
      hso_d = hso_q;
      vso_d = vso_q;
      fs_d  = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow_sx_q <= 10'd0;
      shadow_sy_q <= 10'd0;
      active_sx_q <= 10'd0;
      active_sy_q <= 10'd0;
      v1_q        <= 1'b0;
      fx1_q       <= 3'd0;
      fy1_q       <= 3'd0;
      side1_q     <= SIDE_IDLE;
      tmap_addr_q <= 13'd0;
      v2_q        <= 1'b0;
      fx2_q       <= 3'd0;
      fy2_q       <= 3'd0;
      side2_q     <= SIDE_IDLE;
      v3_q        <= 1'b0;
      side3_q     <= SIDE_IDLE;
      tpix_addr_q <= 14'd0;
      v4_q        <= 1'b0;
      side4_q     <= SIDE_IDLE;
      rgb_q       <= 12'h000;
      hso_q       <= 1'b1;
      vso_q       <= 1'b1;
      fs_q        <= 1'b0;
    end else begin
      shadow_sx_q <= shadow_sx_d;
      shadow_sy_q <= shadow_sy_d;
      active_sx_q <= active_sx_d;
      active_sy_q <= active_sy_d;
      v1_q        <= v1_d;
      fx1_q       <= fx1_d;
      fy1_q       <= fy1_d;
      side1_q     <= side1_d;
      tmap_addr_q <= tmap_addr_d;
      v2_q        <= v2_d;
      fx2_q       <= fx2_d;
      fy2_q       <= fy2_d;
      side2_q     <= side2_d;
      v3_q        <= v3_d;
      side3_q     <= side3_d;
      tpix_addr_q <= tpix_addr_d;
      v4_q        <= v4_d;
      side4_q     <= side4_d;
      rgb_q       <= rgb_d;
      hso_q       <= hso_d;
      vso_q       <= vso_d;
      fs_q        <= fs_d;
    end
  end

  assign tmap_addr   = tmap_addr_q;
  assign tpix_addr   = tpix_addr_q;
  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign h_sync_out  = hso_q;
  assign v_sync_out  = vso_q;
  assign frame_start = fs_q;

endmodule
